// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// ID-stage hazard unit. It combines the EX-stage load-use check with a
// registered scoreboard of destinations owned by in-flight long-latency ops
// (variable-latency loads, mul/div). It produces the IF/ID stall and a reason
// code, and it limits how many long ops can be outstanding at once.
//
// Parameter constraints: 2**REG_AW >= NUM_REGS,
// 1 <= MAX_OUTSTANDING <= NUM_REGS-1, and CNT_W wide enough to hold
// MAX_OUTSTANDING.
//
// Optional build macro HAZARD_SCOREBOARD_PERF_EN adds two saturating 32-bit
// performance counters: cycles stalled, and cycles stalled because the
// outstanding limit is reached.
module hazard_scoreboard #(
    parameter int NUM_REGS        = 32,
    parameter int REG_AW          = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   rs1_id,
    input  logic [REG_AW-1:0]   rs2_id,
    input  logic                rs1_used_id,
    input  logic                rs2_used_id,
    input  logic [REG_AW-1:0]   rd_id,
    input  logic                long_op_id,
    input  logic                hold_id,
    input  logic [REG_AW-1:0]   rd_ex,
    input  logic                mem_read_ex,
    input  logic                lc_valid,
    input  logic [REG_AW-1:0]   lc_rd,
    output logic                stall,
    output logic [1:0]          stall_reason,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [CNT_W-1:0]    outstanding
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]         perf_stall_cycles,
    output logic [31:0]         perf_full_cycles
`endif
);

    typedef enum logic [1:0] {
        REASON_NONE     = 2'd0,
        REASON_LOAD_USE = 2'd1,
        REASON_PENDING  = 2'd2,
        REASON_FULL     = 2'd3
    } reason_e;

    // Scoreboard state. Register 0 never gets a busy bit, so long ops that
    // target x0 are tracked by their own small counter; this lets lc_rd==0
    // retire them without ever making x0 look busy to the hazard checks.
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    outstanding_q, outstanding_d;
    logic [CNT_W-1:0]    zero_pending_q, zero_pending_d;

    logic    load_use;
    logic    raw;
    logic    waw;
    logic    full;
    logic    stall_int;
    reason_e reason;
    logic    issue;
    logic    retire;
    logic    lc_busy;

    // Returns the registered busy bit for register r. Register 0 and any
    // address beyond NUM_REGS read as not busy. The loop avoids indexing
    // with an address that could be wider than the bitmap.
    function automatic logic busy_bit(input logic [REG_AW-1:0]   r,
                                      input logic [NUM_REGS-1:0] busy);
        logic hit;
        hit = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (r == REG_AW'(i)) begin
                hit = busy[i];
            end
        end
        return hit;
    endfunction

    // Effective pending status. A register that completes this cycle is
    // already free, because the regfile writes it through to the reader.
    function automatic logic pend_eff(input logic [REG_AW-1:0]   r,
                                      input logic [NUM_REGS-1:0] busy,
                                      input logic                lcv,
                                      input logic [REG_AW-1:0]   lcr);
        return busy_bit(r, busy) & ~(lcv & (lcr == r));
    endfunction

    // Hazard detection and stall/reason selection. This path is purely
    // combinational so the bubble is inserted in the same cycle. Load-use
    // takes priority over pending RAW/WAW, which takes priority over full.
    always_comb begin
        load_use = mem_read_ex & (rd_ex != '0) &
                   ((rs1_used_id & (rs1_id == rd_ex)) |
                    (rs2_used_id & (rs2_id == rd_ex)));
        raw      = (rs1_used_id & pend_eff(rs1_id, busy_q, lc_valid, lc_rd)) |
                   (rs2_used_id & pend_eff(rs2_id, busy_q, lc_valid, lc_rd));
        waw      = pend_eff(rd_id, busy_q, lc_valid, lc_rd);
        full     = long_op_id & (outstanding_q == CNT_W'(MAX_OUTSTANDING));

        stall_int = id_valid & (load_use | raw | waw | full);

        reason = REASON_NONE;
        if (stall_int) begin
            if (load_use) begin
                reason = REASON_LOAD_USE;
            end else if (raw | waw) begin
                reason = REASON_PENDING;
            end else begin
                reason = REASON_FULL;
            end
        end
    end

    // Issue and retire events. A completion only retires something when it
    // names a register that is actually pending (or a pending x0 op), so
    // spurious or post-reset completions cannot underflow the counters.
    always_comb begin
        issue   = id_valid & long_op_id & ~stall_int & ~hold_id;
        lc_busy = busy_bit(lc_rd, busy_q);
        if (lc_rd == '0) begin
            retire = lc_valid & (zero_pending_q != '0);
        end else begin
            retire = lc_valid & lc_busy;
        end
    end

    // Next-state for the busy bitmap. The clear from a completion is applied
    // first and the set from an issue second, so a new owner of the same
    // register supersedes the completing one.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (lc_valid && (lc_rd == REG_AW'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (issue && (rd_id == REG_AW'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Next-state for the outstanding counter and the x0 tracker. An issue
    // and a retire in the same cycle cancel out. The full stall keeps the
    // count from ever exceeding MAX_OUTSTANDING.
    always_comb begin
        outstanding_d  = outstanding_q;
        zero_pending_d = zero_pending_q;
        case ({issue, retire})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
        case ({issue & (rd_id == '0), retire & (lc_rd == '0)})
            2'b10:   zero_pending_d = zero_pending_q + CNT_W'(1);
            2'b01:   zero_pending_d = zero_pending_q - CNT_W'(1);
            default: zero_pending_d = zero_pending_q;
        endcase
    end

    // Scoreboard registers. Reset drops all pending ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q         <= '0;
            outstanding_q  <= '0;
            zero_pending_q <= '0;
        end else begin
            busy_q         <= busy_d;
            outstanding_q  <= outstanding_d;
            zero_pending_q <= zero_pending_d;
        end
    end

    assign stall        = stall_int;
    assign stall_reason = reason;
    assign busy_vec     = busy_q;
    assign outstanding  = outstanding_q;

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_full_q, perf_full_d;

    // Saturating counters for stalled cycles and cycles stalled only by the
    // outstanding limit.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_full_d  = perf_full_q;
        if (stall_int && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if ((reason == REASON_FULL) && (perf_full_q != 32'hFFFF_FFFF)) begin
            perf_full_d = perf_full_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_full_q  <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_full_q  <= perf_full_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_full_cycles  = perf_full_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Directed scenarios followed by a randomized phase. A reference model works
// from the hazard rules: a set of pending registers, a count of in-flight
// long ops, and a count of in-flight ops that target x0.
module tb_hazard_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;
    localparam int MAXO     = 4;
    localparam int CNT_W    = 3;

    logic                clk;
    logic                rst;
    logic                id_valid;
    logic [REG_AW-1:0]   rs1_id;
    logic [REG_AW-1:0]   rs2_id;
    logic                rs1_used_id;
    logic                rs2_used_id;
    logic [REG_AW-1:0]   rd_id;
    logic                long_op_id;
    logic                hold_id;
    logic [REG_AW-1:0]   rd_ex;
    logic                mem_read_ex;
    logic                lc_valid;
    logic [REG_AW-1:0]   lc_rd;
    logic                stall;
    logic [1:0]          stall_reason;
    logic [NUM_REGS-1:0] busy_vec;
    logic [CNT_W-1:0]    outstanding;
`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0]         perf_stall_cycles;
    logic [31:0]         perf_full_cycles;
`endif

    hazard_scoreboard #(
        .NUM_REGS(NUM_REGS),
        .REG_AW(REG_AW),
        .MAX_OUTSTANDING(MAXO),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .id_valid(id_valid),
        .rs1_id(rs1_id),
        .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id),
        .rs2_used_id(rs2_used_id),
        .rd_id(rd_id),
        .long_op_id(long_op_id),
        .hold_id(hold_id),
        .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex),
        .lc_valid(lc_valid),
        .lc_rd(lc_rd),
        .stall(stall),
        .stall_reason(stall_reason),
        .busy_vec(busy_vec),
        .outstanding(outstanding)
`ifdef HAZARD_SCOREBOARD_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_full_cycles(perf_full_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int compCount = 0;
    int errCount  = 0;

    // Reference model state
    bit mPend[NUM_REGS];
    int mOut;
    int mZero;

    // Outputs sampled during the most recent applyStimulus call
    logic       lastStall;
    logic [1:0] lastReason;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compCount++;
        assert (obs === exp)
        else begin
            errCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pendNow(input int r, input bit lcV, input int lcR);
        if (r == 0) return 1'b0;
        if (lcV && lcR == r) return 1'b0;
        return mPend[r];
    endfunction

    function automatic logic [31:0] modelBusy();
        logic [31:0] v;
        v = '0;
        for (int i = 1; i < NUM_REGS; i++) v[i] = mPend[i];
        return v;
    endfunction

    // Drives one cycle of inputs. It checks the combinational outputs and the
    // registered state against the model, then advances the model at the edge.
    task automatic applyStimulus(input bit rstV, input bit idV, input int r1, input int r2,
                                 input bit u1, input bit u2, input int rd, input bit lng,
                                 input bit hold, input int rdEx, input bit mr,
                                 input bit lcV, input int lcR);
        bit lu, rawH, wawH, fullH, expStall, issue, retire;
        int expReason;
        @(negedge clk);
        rst         = rstV;
        id_valid    = idV;
        rs1_id      = REG_AW'(r1);
        rs2_id      = REG_AW'(r2);
        rs1_used_id = u1;
        rs2_used_id = u2;
        rd_id       = REG_AW'(rd);
        long_op_id  = lng;
        hold_id     = hold;
        rd_ex       = REG_AW'(rdEx);
        mem_read_ex = mr;
        lc_valid    = lcV;
        lc_rd       = REG_AW'(lcR);
        #1;
        lu       = mr && (rdEx != 0) && ((u1 && r1 == rdEx) || (u2 && r2 == rdEx));
        rawH     = (u1 && pendNow(r1, lcV, lcR)) || (u2 && pendNow(r2, lcV, lcR));
        wawH     = pendNow(rd, lcV, lcR);
        fullH    = lng && (mOut == MAXO);
        expStall = idV && (lu || rawH || wawH || fullH);
        if (!expStall)           expReason = 0;
        else if (lu)             expReason = 1;
        else if (rawH || wawH)   expReason = 2;
        else                     expReason = 3;
        lastStall  = stall;
        lastReason = stall_reason;
        checkOutput("stall", 32'(stall), 32'(expStall));
        checkOutput("stall_reason", 32'(stall_reason), 32'(expReason));
        checkOutput("busy_vec", busy_vec, modelBusy());
        checkOutput("outstanding", 32'(outstanding), 32'(mOut));
        issue  = idV && lng && !expStall && !hold;
        retire = lcV && ((lcR == 0) ? (mZero > 0) : mPend[lcR]);
        @(posedge clk);
        if (rstV) begin
            foreach (mPend[i]) mPend[i] = 1'b0;
            mOut  = 0;
            mZero = 0;
        end else begin
            if (retire) begin
                if (lcR == 0) mZero--;
                else          mPend[lcR] = 1'b0;
                mOut--;
            end
            if (issue) begin
                if (rd == 0) mZero++;
                else         mPend[rd] = 1'b1;
                mOut++;
            end
        end
    endtask

    initial begin
        int q[$];
        bit idV, u1, u2, lng, hold, mr, lcV, rstV;
        int r1, r2, rd, rdEx, lcR;

        foreach (mPend[i]) mPend[i] = 1'b0;
        mOut  = 0;
        mZero = 0;

        rst = 1'b1; id_valid = 1'b0; rs1_id = '0; rs2_id = '0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0; rd_id = '0; long_op_id = 1'b0;
        hold_id = 1'b0; rd_ex = '0; mem_read_ex = 1'b0; lc_valid = 1'b0; lc_rd = '0;

        $display("[TB] reset");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("reset_busy", busy_vec, 32'd0);
        checkOutput("reset_outstanding", 32'(outstanding), 32'd0);
        checkOutput("reset_stall", 32'(stall), 32'd0);

        $display("[TB] load-use");
        applyStimulus(0, 1, 5, 0, 1, 0, 8, 0, 0, 5, 1, 0, 0);
        checkOutput("lu_stall", 32'(lastStall), 32'd1);
        checkOutput("lu_reason", 32'(lastReason), 32'd1);
        applyStimulus(0, 1, 0, 0, 1, 0, 8, 0, 0, 0, 1, 0, 0);
        checkOutput("lu_rd0_stall", 32'(lastStall), 32'd0);

        $display("[TB] RAW on long op");
        applyStimulus(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 7, 0, 1, 8, 0, 0, 0, 0, 0, 0);
        checkOutput("raw_stall", 32'(lastStall), 32'd1);
        checkOutput("raw_reason", 32'(lastReason), 32'd2);
        applyStimulus(0, 1, 0, 7, 0, 1, 8, 0, 0, 0, 0, 1, 7);
        checkOutput("raw_release", 32'(lastStall), 32'd0);
        #1;
        checkOutput("raw_bit7_clear", 32'(busy_vec[7]), 32'd0);

        $display("[TB] WAW");
        applyStimulus(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0);
        checkOutput("waw_reason", 32'(lastReason), 32'd2);
        applyStimulus(0, 1, 0, 0, 0, 0, 9, 0, 0, 0, 0, 1, 9);
        checkOutput("waw_release", 32'(lastStall), 32'd0);

        $display("[TB] full");
        for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 0, 0, 0, 0, i, 1, 0, 0, 0, 0, 0);
        #1;
        checkOutput("full_count", 32'(outstanding), 32'd4);
        applyStimulus(0, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0);
        checkOutput("full_reason", 32'(lastReason), 32'd3);
        applyStimulus(0, 1, 12, 13, 1, 1, 11, 0, 0, 0, 0, 0, 0);
        checkOutput("full_add_free", 32'(lastStall), 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 1, 1);
        checkOutput("full_no_bypass", 32'(lastReason), 32'd3);
        applyStimulus(0, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0);
        checkOutput("full_fifth_issue", 32'(lastStall), 32'd0);

        $display("[TB] simultaneous set/clear");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        applyStimulus(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 3);
        #1;
        checkOutput("sim_bit3", 32'(busy_vec[3]), 32'd1);
        checkOutput("sim_count", 32'(outstanding), 32'd3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
        #1;
        checkOutput("spurious_count", 32'(outstanding), 32'd3);

        $display("[TB] reset with ops outstanding");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("midreset_busy", busy_vec, 32'd0);
        checkOutput("midreset_count", 32'(outstanding), 32'd0);
`ifdef HAZARD_SCOREBOARD_PERF_EN
        checkOutput("perf_stall_reset", perf_stall_cycles, 32'd0);
        checkOutput("perf_full_reset", perf_full_cycles, 32'd0);
`endif

        $display("[TB] randomized phase");
        for (int n = 0; n < 1500; n++) begin
            rstV = ($urandom_range(0, 199) == 0);
            idV  = ($urandom_range(0, 9) < 8);
            r1   = $urandom_range(0, 15);
            r2   = $urandom_range(0, 15);
            u1   = $urandom_range(0, 1) == 1;
            u2   = $urandom_range(0, 1) == 1;
            rd   = $urandom_range(0, 15);
            lng  = ($urandom_range(0, 9) < 4);
            hold = ($urandom_range(0, 9) == 0);
            rdEx = $urandom_range(0, 15);
            mr   = ($urandom_range(0, 4) == 0);
            lcV  = ($urandom_range(0, 9) < 4);
            q.delete();
            for (int i = 1; i < 16; i++) if (mPend[i]) q.push_back(i);
            if (mZero > 0) q.push_back(0);
            if (q.size() > 0 && $urandom_range(0, 9) < 7)
                lcR = q[$urandom_range(0, q.size() - 1)];
            else
                lcR = $urandom_range(0, 15);
            applyStimulus(rstV, idV, r1, r2, u1, u2, rd, lng, hold, rdEx, mr, lcV, lcR);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
